nios2_oci_dct_ctrl: RTL and testbench

Sequencer for the Nios II OCI direct-control-transfer (DCT) trace buffer. Packs 2-bit DCT codes from the instruction-trace logic into a 30-bit buffer with a 4-bit count. Emits packed 36-bit frames to the on-chip trace FIFO over a valid/ready handshake on buffer-full, on explicit flush, or when trace is disabled. Sits between the OCI itrace unit and the trace memory, and exports the live `dct_buffer`/`dct_count` for the debug test bench.

---
 rtl/nios2_oci_trace_pkg.sv | 24 ++
 rtl/nios2_oci_frame_reg.sv | 45 ++++
 rtl/nios2_oci_dct_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_nios2_oci_dct_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/nios2_oci_trace_pkg.sv
// Shared constants and types for the Nios II OCI trace path.
package nios2_oci_trace_pkg;

  localparam int DCT_DEPTH = 15;
  localparam int CODE_W    = 2;
  localparam int BUF_W     = DCT_DEPTH * CODE_W;
  localparam int CNT_W     = 4;
  localparam int FT_W      = 2;
  localparam int FRAME_W   = 36;

  localparam logic [CNT_W-1:0] DCT_CNT_FULL = 4'd15;
  localparam logic [CNT_W-1:0] DCT_CNT_LAST = 4'd14;

  localparam logic [FT_W-1:0] DCT_FT_NORMAL = 2'b01;
  localparam logic [FT_W-1:0] DCT_FT_FLUSH  = 2'b10;
  localparam logic [FT_W-1:0] DCT_FT_LOSS   = 2'b11;

  typedef enum logic [1:0] {
    ST_ACCUM      = 2'd0,
    ST_FULL_WAIT  = 2'd1,
    ST_FLUSH_WAIT = 2'd2
  } dct_state_t;

endpackage

// File: rtl/nios2_oci_frame_reg.sv
// Single-entry valid/ready output register holding one packed trace frame.
module nios2_oci_frame_reg
  import nios2_oci_trace_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               frame_ready,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data
);

  logic               valid_q, valid_d;
  logic [FRAME_W-1:0] data_q, data_d;

  // Load only happens when the slot is free, so it always wins over a drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (frame_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot state; reset discards any pending frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign frame_valid = valid_q;
  assign frame_data  = data_q;

endmodule

// File: rtl/nios2_oci_dct_ctrl.sv
// DCT code packer and frame sequencer between the OCI itrace unit and trace FIFO.
module nios2_oci_dct_ctrl
  import nios2_oci_trace_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               trc_on,
  input  logic               dct_valid,
  input  logic [CODE_W-1:0]  dct_code,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow
);

  dct_state_t       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lost_q, lost_d;
  logic             pend_q, pend_d;
  logic             trc_prev_q, trc_prev_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic               flush_evt, code_in, out_free;
  logic [BUF_W-1:0]   packed_buf, fresh_buf;
  logic [CNT_W-1:0]   fresh_cnt;
  logic               load;
  logic [FT_W-1:0]    load_type, final_type;
  logic [BUF_W-1:0]   load_buf;
  logic [CNT_W-1:0]   load_cnt;
  logic [FRAME_W-1:0] load_data;

  assign flush_evt  = flush_req | (trc_prev_q & ~trc_on);
  assign code_in    = trc_on & dct_valid;
  assign out_free   = ~frame_valid | frame_ready;
  assign packed_buf = {buf_q[BUF_W-CODE_W-1:0], dct_code};
  // A code arriving on a wait/flush handoff starts the next buffer.
  assign fresh_buf  = code_in ? {{(BUF_W-CODE_W){1'b0}}, dct_code} : {BUF_W{1'b0}};
  assign fresh_cnt  = code_in ? 4'd1 : 4'd0;

  // Next-state, packing and frame capture decisions.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    lost_d     = lost_q;
    pend_d     = pend_q;
    trc_prev_d = trc_on;
    done_d     = 1'b0;
    ovf_d      = 1'b0;
    load       = 1'b0;
    load_type  = DCT_FT_NORMAL;
    load_buf   = buf_q;
    load_cnt   = cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (flush_evt && (cnt_q != 4'd0)) begin
          if (out_free) begin
            load      = 1'b1;
            load_type = DCT_FT_FLUSH;
            done_d    = 1'b1;
            buf_d     = fresh_buf;
            cnt_d     = fresh_cnt;
          end else begin
            state_d = ST_FLUSH_WAIT;
            if (code_in) begin
              buf_d = packed_buf;
              cnt_d = cnt_q + 4'd1;
            end else begin
              buf_d = buf_q;
            end
          end
        end else begin
          done_d = flush_evt;
          if (code_in && (cnt_q == DCT_CNT_LAST)) begin
            if (out_free) begin
              load     = 1'b1;
              load_buf = packed_buf;
              load_cnt = DCT_CNT_FULL;
              buf_d    = {BUF_W{1'b0}};
              cnt_d    = 4'd0;
            end else begin
              state_d = ST_FULL_WAIT;
              buf_d   = packed_buf;
              cnt_d   = DCT_CNT_FULL;
            end
          end else if (code_in) begin
            buf_d = packed_buf;
            cnt_d = cnt_q + 4'd1;
          end else begin
            buf_d = buf_q;
          end
        end
      end
      ST_FULL_WAIT: begin
        if (out_free) begin
          load    = 1'b1;
          done_d  = pend_q | flush_evt;
          pend_d  = 1'b0;
          state_d = ST_ACCUM;
          buf_d   = fresh_buf;
          cnt_d   = fresh_cnt;
        end else begin
          pend_d = pend_q | flush_evt;
          ovf_d  = code_in;
          lost_d = lost_q | code_in;
        end
      end
      ST_FLUSH_WAIT: begin
        if (out_free) begin
          load      = 1'b1;
          load_type = DCT_FT_FLUSH;
          done_d    = 1'b1;
          state_d   = ST_ACCUM;
          buf_d     = fresh_buf;
          cnt_d     = fresh_cnt;
        end else if (code_in && (cnt_q == DCT_CNT_FULL)) begin
          ovf_d  = 1'b1;
          lost_d = 1'b1;
        end else if (code_in) begin
          buf_d = packed_buf;
          cnt_d = cnt_q + 4'd1;
        end else begin
          buf_d = buf_q;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
    // Loss marking overrides the frame type and re-arms on capture.
    if (load) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_d;
    end
  end

  assign final_type = lost_q ? DCT_FT_LOSS : load_type;
  assign load_data  = {final_type, load_cnt, load_buf};

  // Sequencer state, packing buffer and registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ACCUM;
      buf_q      <= '0;
      cnt_q      <= '0;
      lost_q     <= 1'b0;
      pend_q     <= 1'b0;
      trc_prev_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      lost_q     <= lost_d;
      pend_q     <= pend_d;
      trc_prev_q <= trc_prev_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  nios2_oci_frame_reg u_frame_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_data   (load_data),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign flush_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_nios2_oci_dct_ctrl.sv
// Directed bench for nios2_oci_dct_ctrl with hand-computed frame values.
module tb_nios2_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset, trc_on, dct_valid, flush_req, frame_ready;
  logic [1:0]  dct_code;
  logic        flush_done, frame_valid, overflow;
  logic [35:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  nios2_oci_dct_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .trc_on      (trc_on),
    .dct_valid   (dct_valid),
    .dct_code    (dct_code),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code);
    dct_valid = 1'b1;
    dct_code  = code;
    tick();
    dct_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trc_on = 1'b0; dct_valid = 1'b0; dct_code = 2'b00;
    flush_req = 1'b0; frame_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_data", frame_data, 36'h0);
    chk("rst_count", dct_count, 4'd0);
    chk("rst_buffer", dct_buffer, 30'h0);
    chk("rst_done", flush_done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0; trc_on = 1'b1;
    tick();

    // full frame with ready high
    frame_ready = 1'b1;
    for (int i = 0; i < 14; i++) send(2'b10);
    chk("full_cnt14", dct_count, 4'd14);
    chk("full_novalid", frame_valid, 1'b0);
    send(2'b10);
    chk("full_valid", frame_valid, 1'b1);
    chk("full_data", frame_data, {2'b01, 4'd15, 30'h2AAAAAAA});
    chk("full_cnt0", dct_count, 4'd0);
    tick();
    chk("full_1cyc", frame_valid, 1'b0);

    // flush partial, then empty flush
    send(2'b01); send(2'b10); send(2'b11);
    chk("part_buf", dct_buffer, 30'h1B);
    chk("part_cnt", dct_count, 4'd3);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("flush_valid", frame_valid, 1'b1);
    chk("flush_data", frame_data, {2'b10, 4'd3, 30'h1B});
    chk("flush_done", flush_done, 1'b1);
    chk("flush_cnt0", dct_count, 4'd0);
    tick();
    chk("flush_drain", frame_valid, 1'b0);
    chk("flush_done_pulse", flush_done, 1'b0);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("eflush_done", flush_done, 1'b1);
    chk("eflush_noframe", frame_valid, 1'b0);
    tick();

    // backpressure with loss
    frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'b11);
    chk("bp_f1_valid", frame_valid, 1'b1);
    for (int i = 0; i < 15; i++) send(2'b01);
    chk("bp_cnt15", dct_count, 4'd15);
    chk("bp_noovf", overflow, 1'b0);
    send(2'b10);
    chk("bp_ovf1", overflow, 1'b1);
    send(2'b10);
    chk("bp_ovf2", overflow, 1'b1);
    chk("bp_cnt_hold", dct_count, 4'd15);
    tick();
    chk("bp_ovf_end", overflow, 1'b0);
    chk("bp_f1_stable", frame_data, {2'b01, 4'd15, 30'h3FFFFFFF});
    frame_ready = 1'b1; tick();
    chk("bp_f2_valid", frame_valid, 1'b1);
    chk("bp_f2_loss", frame_data, {2'b11, 4'd15, 30'h15555555});
    chk("bp_cnt0", dct_count, 4'd0);
    tick();
    chk("bp_drained", frame_valid, 1'b0);

    // drain and refill in the same cycle; flush absorbed while full
    frame_ready = 1'b0;
    for (int i = 0; i < 30; i++) send(2'b11);
    flush_req = 1'b1; tick(); flush_req = 1'b0;
    chk("fw_absorb", flush_done, 1'b0);
    chk("fw_held", frame_valid, 1'b1);
    frame_ready = 1'b1; dct_valid = 1'b1; dct_code = 2'b01;
    tick();
    dct_valid = 1'b0;
    chk("refill_cnt", dct_count, 4'd1);
    chk("refill_buf", dct_buffer, 30'h1);
    chk("refill_frame", frame_data, {2'b01, 4'd15, 30'h3FFFFFFF});
    chk("refill_done", flush_done, 1'b1);
    tick();
    chk("refill_drain", frame_valid, 1'b0);

    // trace disable flushes count 5
    send(2'b10); send(2'b11); send(2'b00); send(2'b01);
    chk("trc_cnt5", dct_count, 4'd5);
    trc_on = 1'b0; tick();
    chk("trc_frame", frame_data, {2'b10, 4'd5, 30'h1B1});
    chk("trc_valid", frame_valid, 1'b1);
    chk("trc_done", flush_done, 1'b1);
    send(2'b11);
    chk("trc_off_cnt", dct_count, 4'd0);

    // reset in FULL_WAIT
    trc_on = 1'b1; frame_ready = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) send(2'b11);
    chk("rw_cnt15", dct_count, 4'd15);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rw_valid", frame_valid, 1'b0);
    chk("rw_data", frame_data, 36'h0);
    chk("rw_cnt", dct_count, 4'd0);
    chk("rw_buf", dct_buffer, 30'h0);
    send(2'b10);
    chk("rw_new_cnt", dct_count, 4'd1);
    chk("rw_new_buf", dct_buffer, 30'h2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
